// File: rtl/ex_alu_branch_unit.sv
// Execute stage: 16-op ALU with NZCV, condition check against the registered flags, branch target and link decisions.
// Every output is combinational except flags_q, which updates one cycle after a passing S-instruction. There is no backpressure.
module ex_alu_branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             shifter_carry,
  input  logic [3:0]       alu_op,
  input  logic             s_enable,
  input  logic [3:0]       cond,
  input  logic             b_instr,
  input  logic             bl_instr,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [23:0]      imm24,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       alu_flags,
  output logic [3:0]       flags_q,
  output logic             cond_true,
  output logic             no_writeback,
  output logic [WIDTH-1:0] target_addr,
  output logic             branch_taken,
  output logic             bl_write
);

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             is_arith;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  // Subtractions become X + ~Y + carry, so C is the ARM-style not-borrow.
  always_comb begin
    add_x     = a_in;
    add_y     = b_in;
    add_cin   = 1'b0;
    is_arith  = 1'b1;
    logic_res = '0;
    unique case (alu_op)
      4'h0, 4'h8: begin is_arith = 1'b0; logic_res = a_in & b_in;  end
      4'h1, 4'h9: begin is_arith = 1'b0; logic_res = a_in ^ b_in;  end
      4'h2, 4'hA: begin add_y = ~b_in; add_cin = 1'b1; end
      4'h3:       begin add_x = b_in; add_y = ~a_in; add_cin = 1'b1; end
      4'h4, 4'hB: begin add_cin = 1'b0; end
      4'h5:       begin add_cin = flags_q[1]; end
      4'h6:       begin add_y = ~b_in; add_cin = flags_q[1]; end
      4'h7:       begin add_x = b_in; add_y = ~a_in; add_cin = flags_q[1]; end
      4'hC:       begin is_arith = 1'b0; logic_res = a_in | b_in;  end
      4'hD:       begin is_arith = 1'b0; logic_res = b_in;         end
      4'hE:       begin is_arith = 1'b0; logic_res = a_in & ~b_in; end
      4'hF:       begin is_arith = 1'b0; logic_res = ~b_in;        end
    endcase
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign alu_out = is_arith ? sum[WIDTH-1:0] : logic_res;

  always_comb begin
    flag_n = alu_out[WIDTH-1];
    flag_z = (alu_out == '0);
    if (is_arith) begin
      flag_c = sum[WIDTH];
      flag_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
    end else begin
      flag_c = shifter_carry;
      flag_v = flags_q[0];
    end
  end

  assign alu_flags    = {flag_n, flag_z, flag_c, flag_v};
  assign no_writeback = (alu_op[3:2] == 2'b10);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      4'h0: cond_true = flags_q[2];
      4'h1: cond_true = !flags_q[2];
      4'h2: cond_true = flags_q[1];
      4'h3: cond_true = !flags_q[1];
      4'h4: cond_true = flags_q[3];
      4'h5: cond_true = !flags_q[3];
      4'h6: cond_true = flags_q[0];
      4'h7: cond_true = !flags_q[0];
      4'h8: cond_true = flags_q[1] && !flags_q[2];
      4'h9: cond_true = !flags_q[1] || flags_q[2];
      4'hA: cond_true = (flags_q[3] == flags_q[0]);
      4'hB: cond_true = (flags_q[3] != flags_q[0]);
      4'hC: cond_true = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'hD: cond_true = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      flags_q <= 4'b0000;
    end else if (s_enable && cond_true) begin
      flags_q <= alu_flags;
    end
  end

  assign target_addr  = pc_in + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
  assign branch_taken = (b_instr || bl_instr) && cond_true;
  assign bl_write     = bl_instr && cond_true;

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Directed vector table, branch/reset sequences and randomized checks against an arithmetic reference model.
module tb_ex_alu_branch_unit;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, pc_in = '0;
  logic        shifter_carry = 1'b0, s_enable = 1'b0, b_instr = 1'b0, bl_instr = 1'b0;
  logic [3:0]  alu_op = '0, cond = 4'hE;
  logic [23:0] imm24 = '0;
  logic [31:0] alu_out, target_addr;
  logic [3:0]  alu_flags, flags_q;
  logic        cond_true, no_writeback, branch_taken, bl_write;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  ex_alu_branch_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .CLR(CLR), .a_in(a_in), .b_in(b_in), .shifter_carry(shifter_carry),
    .alu_op(alu_op), .s_enable(s_enable), .cond(cond), .b_instr(b_instr),
    .bl_instr(bl_instr), .pc_in(pc_in), .imm24(imm24), .alu_out(alu_out),
    .alu_flags(alu_flags), .flags_q(flags_q), .cond_true(cond_true),
    .no_writeback(no_writeback), .target_addr(target_addr),
    .branch_taken(branch_taken), .bl_write(bl_write)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU: works on values as integers, returns {result, N, Z, C, V}.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic shc, input logic [3:0] fq);
    logic [31:0] r, xo, yo;
    logic        c, v;
    bit          arith, sub;
    longint      ux, uy, sx, sy, k, sres;
    arith = 1; sub = 0; k = 0; xo = a; yo = b; r = '0; c = shc; v = fq[0];
    case (op)
      4'h0, 4'h8: begin arith = 0; r = a & b; end
      4'h1, 4'h9: begin arith = 0; r = a ^ b; end
      4'h2, 4'hA: sub = 1;
      4'h3:       begin sub = 1; xo = b; yo = a; end
      4'h5:       k = longint'(fq[1]);
      4'h6:       begin sub = 1; k = longint'(!fq[1]); end
      4'h7:       begin sub = 1; xo = b; yo = a; k = longint'(!fq[1]); end
      4'hC:       begin arith = 0; r = a | b; end
      4'hD:       begin arith = 0; r = b; end
      4'hE:       begin arith = 0; r = a & ~b; end
      4'hF:       begin arith = 0; r = ~b; end
      default:    ;
    endcase
    if (arith) begin
      ux = longint'(xo); uy = longint'(yo);
      sx = longint'($signed(xo)); sy = longint'($signed(yo));
      if (sub) begin
        r = 32'(ux - uy - k);
        c = (ux >= uy + k);
        sres = sx - sy - k;
      end else begin
        r = 32'(ux + uy + k);
        c = (ux + uy + k) > 64'h0000_0000_FFFF_FFFF;
        sres = sx + sy + k;
      end
      v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    end
    return {r, r[31], (r == 32'h0), c, v};
  endfunction

  function automatic logic ref_cond(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'h0: return z;          4'h1: return !z;
      4'h2: return c;          4'h3: return !c;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return c && !z;    4'h9: return !c || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        shc, s;
    logic [3:0]  cd;
    logic [31:0] exp_out;
    logic [3:0]  exp_f;
    logic        exp_ct;
    logic [3:0]  exp_q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic shc, input logic s, input logic [3:0] cd,
                              input logic [31:0] eo, input logic [3:0] ef, input logic ect,
                              input logic [3:0] eq);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.shc = shc; t.s = s; t.cd = cd;
    t.exp_out = eo; t.exp_f = ef; t.exp_ct = ect; t.exp_q = eq;
    return t;
  endfunction

  logic [3:0]  mf;
  logic [35:0] m;
  logic [31:0] exp_tgt;
  logic        mct, exp_nwb;

  initial begin
    // flags start at 0000 after reset; each row runs one clock and carries flags to the next
    vecs.push_back(mk(4'h2, 32'd5, 32'd5, 0, 1, 4'hE, 32'h0, 4'b0110, 1, 4'b0110));
    vecs.push_back(mk(4'hD, 32'd0, 32'd7, 0, 0, 4'h0, 32'h7, 4'b0000, 1, 4'b0110));
    vecs.push_back(mk(4'h0, 32'hF0, 32'hFF, 1, 1, 4'h8, 32'hF0, 4'b0010, 0, 4'b0110));
    vecs.push_back(mk(4'h4, 32'h7FFFFFFF, 32'd1, 0, 1, 4'hE, 32'h80000000, 4'b1001, 1, 4'b1001));
    vecs.push_back(mk(4'h4, 32'hFFFFFFFF, 32'd1, 0, 1, 4'hE, 32'h0, 4'b0110, 1, 4'b0110));
    vecs.push_back(mk(4'h5, 32'd2, 32'd3, 0, 0, 4'hE, 32'd6, 4'b0000, 1, 4'b0110));
    vecs.push_back(mk(4'h6, 32'd5, 32'd3, 0, 0, 4'hE, 32'd2, 4'b0010, 1, 4'b0110));
    vecs.push_back(mk(4'h2, 32'd1, 32'd2, 0, 1, 4'hE, 32'hFFFFFFFF, 4'b1000, 1, 4'b1000));
    vecs.push_back(mk(4'h6, 32'd5, 32'd3, 0, 0, 4'hE, 32'd1, 4'b0010, 1, 4'b1000));
    vecs.push_back(mk(4'hA, 32'd3, 32'd5, 0, 1, 4'hE, 32'hFFFFFFFE, 4'b1000, 1, 4'b1000));
    vecs.push_back(mk(4'h8, 32'hF, 32'h0, 0, 0, 4'hB, 32'h0, 4'b0100, 1, 4'b1000));
    vecs.push_back(mk(4'h3, 32'd3, 32'd10, 0, 1, 4'h1, 32'd7, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(4'h7, 32'd3, 32'd10, 0, 1, 4'hF, 32'd7, 4'b0010, 0, 4'b0010));
    vecs.push_back(mk(4'h1, 32'hFFFF0000, 32'h0000FFFF, 1, 1, 4'h2, 32'hFFFFFFFF, 4'b1010, 1, 4'b1010));
    vecs.push_back(mk(4'h9, 32'd5, 32'd5, 0, 1, 4'hA, 32'h0, 4'b0100, 0, 4'b1010));
    vecs.push_back(mk(4'hC, 32'd1, 32'd2, 0, 0, 4'h4, 32'd3, 4'b0000, 1, 4'b1010));
    vecs.push_back(mk(4'hE, 32'hFF, 32'h0F, 0, 0, 4'h5, 32'hF0, 4'b0000, 0, 4'b1010));
    vecs.push_back(mk(4'hF, 32'd0, 32'd0, 0, 1, 4'h7, 32'hFFFFFFFF, 4'b1000, 1, 4'b1000));
    vecs.push_back(mk(4'h2, 32'h80000000, 32'd1, 0, 1, 4'hD, 32'h7FFFFFFF, 4'b0011, 1, 4'b0011));
    vecs.push_back(mk(4'hD, 32'd9, 32'd0, 1, 1, 4'h6, 32'h0, 4'b0111, 1, 4'b0111));
    vecs.push_back(mk(4'h4, 32'd0, 32'd0, 0, 0, 4'h9, 32'h0, 4'b0100, 1, 4'b0111));
    vecs.push_back(mk(4'h4, 32'd1, 32'd1, 0, 1, 4'h3, 32'd2, 4'b0000, 0, 4'b0111));
    vecs.push_back(mk(4'h0, 32'd0, 32'd0, 0, 0, 4'hC, 32'h0, 4'b0101, 0, 4'b0111));

    // reset state
    #3;
    check("rst_flags_q", 32'(flags_q), 32'h0);
    cond = 4'h0; #1; check("rst_cond_eq", 32'(cond_true), 32'h0);
    cond = 4'h1; #1; check("rst_cond_ne", 32'(cond_true), 32'h1);
    cond = 4'hE; #1; check("rst_cond_al", 32'(cond_true), 32'h1);
    #4 CLR = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      alu_op = vecs[i].op; a_in = vecs[i].a; b_in = vecs[i].b;
      shifter_carry = vecs[i].shc; s_enable = vecs[i].s; cond = vecs[i].cd;
      #1;
      exp_nwb = (vecs[i].op >= 4'h8) && (vecs[i].op <= 4'hB);
      check($sformatf("vec%0d_out", i), alu_out, vecs[i].exp_out);
      check($sformatf("vec%0d_flags", i), 32'(alu_flags), 32'(vecs[i].exp_f));
      check($sformatf("vec%0d_cond", i), 32'(cond_true), 32'(vecs[i].exp_ct));
      check($sformatf("vec%0d_nwb", i), 32'(no_writeback), 32'(exp_nwb));
      @(posedge CLK); #1;
      check($sformatf("vec%0d_flags_q", i), 32'(flags_q), 32'(vecs[i].exp_q));
    end
    mf = 4'b0111;

    // branch decisions
    s_enable = 1'b0; pc_in = 32'h100; imm24 = 24'hFFFFFE; cond = 4'hE; bl_instr = 1'b1; #1;
    check("br_target", target_addr, 32'hF8);
    check("bl_taken", 32'(branch_taken), 32'h1);
    check("bl_write", 32'(bl_write), 32'h1);
    cond = 4'hF; #1;
    check("bl_nv_taken", 32'(branch_taken), 32'h0);
    check("bl_nv_write", 32'(bl_write), 32'h0);
    cond = 4'hE; b_instr = 1'b1; #1;
    check("b_bl_taken", 32'(branch_taken), 32'h1);
    check("b_bl_write", 32'(bl_write), 32'h1);
    bl_instr = 1'b0; #1;
    check("b_taken", 32'(branch_taken), 32'h1);
    check("b_no_link", 32'(bl_write), 32'h0);
    pc_in = 32'h0; imm24 = 24'h7FFFFF; #1;
    check("br_max_fwd", target_addr, 32'h01FFFFFC);
    b_instr = 1'b0;

    // randomized run against the reference model
    for (int n = 0; n < 500; n++) begin
      alu_op = 4'($urandom_range(0, 15));
      a_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      b_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      if ($urandom_range(0, 7) == 0) b_in = a_in;
      shifter_carry = 1'($urandom); s_enable = 1'($urandom);
      cond = 4'($urandom_range(0, 15)); b_instr = 1'($urandom); bl_instr = 1'($urandom);
      pc_in = $urandom; imm24 = 24'($urandom);
      #1;
      m = ref_alu(alu_op, a_in, b_in, shifter_carry, mf);
      mct = ref_cond(cond, mf);
      exp_tgt = pc_in + 32'($signed(imm24)) * 32'd4;
      check("rnd_out", alu_out, m[35:4]);
      check("rnd_flags", 32'(alu_flags), 32'(m[3:0]));
      check("rnd_cond", 32'(cond_true), 32'(mct));
      check("rnd_nwb", 32'(no_writeback), 32'(alu_op inside {4'h8, 4'h9, 4'hA, 4'hB}));
      check("rnd_target", target_addr, exp_tgt);
      check("rnd_taken", 32'(branch_taken), 32'((b_instr | bl_instr) & mct));
      check("rnd_blw", 32'(bl_write), 32'(bl_instr & mct));
      @(posedge CLK); #1;
      if (s_enable && mct) mf = m[3:0];
      check("rnd_flags_q", 32'(flags_q), 32'(mf));
    end

    // asynchronous reset in the middle of a cycle
    b_instr = 1'b0; bl_instr = 1'b0;
    alu_op = 4'h2; a_in = 32'd5; b_in = 32'd5; s_enable = 1'b1; cond = 4'hE;
    @(posedge CLK); #1;
    check("mid_pre_flags_q", 32'(flags_q), 32'b0110);
    s_enable = 1'b0; cond = 4'h0; #2;
    check("mid_pre_eq", 32'(cond_true), 32'h1);
    CLR = 1'b0; #1;
    check("mid_rst_flags_q", 32'(flags_q), 32'h0);
    check("mid_rst_eq", 32'(cond_true), 32'h0);
    cond = 4'h1; #1;
    check("mid_rst_ne", 32'(cond_true), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_alu_branch_unit.md
Name: ex_alu_branch_unit

Overview:
- Execute-stage datapath block of the ARM-style 5-stage pipeline.
- Combines three functions:
  - 16-operation ALU with NZCV flag generation and a registered flag (status) register.
  - Branch-target adder.
  - Condition handler that evaluates the instruction condition field and issues branch-taken / BL-link-write decisions.
- The only sequential state is the 4-bit flag register. Everything else is combinational.

Parameters:
- WIDTH, 32, datapath width of operands, result and PC/target.

Ports:
- CLK  in  1  clock; flag register updates on rising edge.
- CLR  in  1  reset, asynchronous, active-low; clears the flag register.
- a_in  in  32  operand A (Rn).
- b_in  in  32  operand B (shifter output).
- shifter_carry  in  1  carry-out from shifter, used as C for logical ops.
- alu_op  in  4  operation select (encoding below).
- s_enable  in  1  S bit: request flag update.
- cond  in  4  instruction condition field [31:28].
- b_instr  in  1  instruction is B.
- bl_instr  in  1  instruction is BL.
- pc_in  in  32  PC value used as branch base.
- imm24  in  24  branch offset field.
- alu_out  out  32  ALU result.
- alu_flags  out  4  combinational {N,Z,C,V} of the current operation.
- flags_q  out  4  registered {N,Z,C,V}.
- cond_true  out  1  condition passes against flags_q.
- no_writeback  out  1  high for TST/TEQ/CMP/CMN.
- target_addr  out  32  branch target.
- branch_taken  out  1  take branch.
- bl_write  out  1  write link register (R14).

Behaviour:
- alu_op encoding, with Cin = flags_q.C:
  - 0 AND: A&B
  - 1 EOR: A^B
  - 2 SUB: A-B
  - 3 RSB: B-A
  - 4 ADD: A+B
  - 5 ADC: A+B+Cin
  - 6 SBC: A-B-!Cin
  - 7 RSC: B-A-!Cin
  - 8 TST: A&B
  - 9 TEQ: A^B
  - A CMP: A-B
  - B CMN: A+B
  - C ORR: A|B
  - D MOV: B
  - E BIC: A&~B
  - F MVN: ~B
- All arithmetic is 32-bit modulo 2^32. Subtraction is computed as X + ~Y + 1, or X + ~Y + Cin for the carry variants.
- Arithmetic-op flags:
  - N = result[31].
  - Z = (result == 0).
  - C = carry-out of the 33-bit add. For subtraction this is NOT borrow, so 5-3 gives C=1 and 3-5 gives C=0.
  - V = signed overflow: operands of the effective addition have the same sign and the result sign differs.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - N and Z from the result.
  - C = shifter_carry.
  - V = flags_q.V (unchanged).
- alu_out always carries the computed result. no_writeback = 1 for ops 8–B, 0 otherwise.
- Flag register:
  - On CLR low (asynchronous), flags_q = 4'b0000.
  - On rising CLK with CLR high, flags_q <= alu_flags only if s_enable & cond_true; otherwise it holds.
  - Ops 8–B update flags only when s_enable = 1. The decoder sets s_enable for them.
- Condition evaluation is combinational on flags_q, i.e. flags from prior instructions:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0
- Branch handling:
  - target_addr = pc_in + (sign_extend(imm24) << 2), modulo 2^32.
  - branch_taken = (b_instr | bl_instr) & cond_true.
  - bl_write = bl_instr & cond_true.
  - If b_instr and bl_instr are both high, treat as BL.
- Same-edge rule: a flag update on edge k affects cond_true only after edge k. A flag-setting instruction does not see its own new flags.
- Reset mid-operation: flags clear immediately. Condition outputs follow combinationally; e.g. EQ becomes false and NE true.
- No latency on combinational outputs. Flag latency is one cycle.

Test Plan:
- Reset: CLR=0 -> flags_q=0000. With cond=0 (EQ) -> cond_true=0; with cond=E -> cond_true=1.
- SUB with s_enable=1, cond=E, A=5, B=5 -> alu_out=0, alu_flags=0110 (Z=1, C=1). After edge, flags_q=0110; cond EQ -> cond_true=1, cond HI -> cond_true=0.
- ADD overflow: A=0x7FFFFFFF, B=1 -> alu_out=0x80000000, N=1, V=1, C=0. Then A=0xFFFFFFFF, B=1 -> alu_out=0, Z=1, C=1, V=0.
- ADC/SBC with flags_q.C=1:
  - ADC 2+3 -> 6.
  - SBC 5-3 -> 2.
  - With C=0, SBC 5-3 -> 1.
- CMP 3,5 with s_enable=1 -> no_writeback=1, flags N=1, C=0. Then cond LT (B) -> cond_true=1. A following instruction with s_enable=0 leaves flags_q unchanged.
- Branch:
  - pc_in=0x100, imm24=0xFFFFFE -> target_addr=0xF8.
  - bl_instr=1, cond=E -> branch_taken=1, bl_write=1.
  - cond=F -> both 0.
  - s_enable=1 with failed cond -> flags_q held.
